// File: rtl/weave_draft_loader.sv
`default_nettype none
// ============================================================================
// Module   : weave_draft_loader
// Purpose  : Pin-side weaving-draft row loader with 4-phase write handshake and
//            pick-by-pick playback; each full pass rotates rows left one bit.
// Option   : WDL_PARITY_EN enables even-parity checking on row writes.
// Revision : 1.0 - initial release
// ============================================================================
module weave_draft_loader #(
  parameter int WIDTH       = 8,
  parameter int DEPTH       = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       load_en,
  input  logic                       wr_stb,
  input  logic [WIDTH-1:0]           wr_data,
  input  logic                       wr_par,
  input  logic                       step,
  output logic                       wr_ack,
  output logic [WIDTH-1:0]           row_out,
  output logic [$clog2(DEPTH)-1:0]   row_idx,
  output logic [$clog2(DEPTH):0]     count,
  output logic [1:0]                 state,
  output logic                       err
);

  localparam int c_aw = $clog2(DEPTH);
  localparam int c_cw = c_aw + 1;
  localparam int c_tw = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_PLAY = 2'd2
  } state_t;

  state_t                 state_q, state_d;
  logic [SYNC_STAGES-1:0] ld_sync_q, ld_sync_d;
  logic [SYNC_STAGES-1:0] stb_sync_q, stb_sync_d;
  logic                   stb_prev_q, stb_prev_d;
  logic                   ack_q, ack_d;
  logic [c_cw-1:0]        count_q, count_d;
  logic [c_aw-1:0]        rd_ptr_q, rd_ptr_d;
  logic [c_tw-1:0]        twist_q, twist_d;
  logic                   err_q, err_d;
  logic [WIDTH-1:0]       row_out_q, row_out_d;
  logic [WIDTH-1:0]       mem_q [DEPTH];

  logic                   ld_s, stb_s, wr_ev, par_bad, mem_we, last_row;

  function automatic logic [WIDTH-1:0] rotl(input logic [WIDTH-1:0] x,
                                            input logic [c_tw-1:0]  n);
    logic [2*WIDTH-1:0] t;
    t = {x, x} << n;
    return t[2*WIDTH-1:WIDTH];
  endfunction

  assign ld_s  = ld_sync_q[SYNC_STAGES-1];
  assign stb_s = stb_sync_q[SYNC_STAGES-1];
  assign wr_ev = stb_s & ~stb_prev_q;

`ifdef WDL_PARITY_EN
  assign par_bad = ^{wr_data, wr_par};
`else
  logic unused_par;
  assign unused_par = &{1'b0, wr_par};
  assign par_bad    = 1'b0;
`endif

  assign last_row = (c_cw'(rd_ptr_q) == (count_q - c_cw'(1)));

  always_comb begin
    ld_sync_d  = {ld_sync_q[SYNC_STAGES-2:0], load_en};
    stb_sync_d = {stb_sync_q[SYNC_STAGES-2:0], wr_stb};
    stb_prev_d = stb_s;
    // Ack holds from the cycle after the event until the synced strobe drops.
    ack_d      = wr_ev | (ack_q & stb_s);

    state_d  = state_q;
    count_d  = count_q;
    rd_ptr_d = rd_ptr_q;
    twist_d  = twist_q;
    err_d    = err_q;
    mem_we   = 1'b0;

    unique case (state_q)
      ST_IDLE: if (ld_s) state_d = ST_LOAD;
      ST_LOAD: if (!ld_s) state_d = (count_q != '0) ? ST_PLAY : ST_IDLE;
      ST_PLAY: if (ld_s) state_d = ST_LOAD;
      default: state_d = ST_IDLE;
    endcase

    if (state_d == ST_LOAD && state_q != ST_LOAD) begin
      count_d  = '0;
      rd_ptr_d = '0;
      twist_d  = '0;
      err_d    = 1'b0;
    end else if (state_q == ST_LOAD && state_d == ST_LOAD && wr_ev) begin
      if (par_bad || count_q == c_cw'(DEPTH)) begin
        err_d = 1'b1;
      end else begin
        mem_we  = 1'b1;
        count_d = count_q + c_cw'(1);
      end
    end else if (state_q == ST_PLAY && state_d == ST_PLAY && step) begin
      if (last_row) begin
        rd_ptr_d = '0;
        twist_d  = twist_q + c_tw'(1);
      end else begin
        rd_ptr_d = rd_ptr_q + c_aw'(1);
      end
    end

    // Looking up with the next pointer keeps step-to-output latency at one cycle.
    row_out_d = (state_d == ST_PLAY) ? rotl(mem_q[rd_ptr_d], twist_d) : '0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      ld_sync_q  <= '0;
      stb_sync_q <= '0;
      stb_prev_q <= 1'b0;
      ack_q      <= 1'b0;
      count_q    <= '0;
      rd_ptr_q   <= '0;
      twist_q    <= '0;
      err_q      <= 1'b0;
      row_out_q  <= '0;
    end else begin
      state_q    <= state_d;
      ld_sync_q  <= ld_sync_d;
      stb_sync_q <= stb_sync_d;
      stb_prev_q <= stb_prev_d;
      ack_q      <= ack_d;
      count_q    <= count_d;
      rd_ptr_q   <= rd_ptr_d;
      twist_q    <= twist_d;
      err_q      <= err_d;
      row_out_q  <= row_out_d;
    end
  end

  // Row storage carries no reset; only written rows are ever played back.
  always_ff @(posedge clk) begin
    if (mem_we) mem_q[count_q[c_aw-1:0]] <= wr_data;
  end

  assign wr_ack  = ack_q;
  assign row_out = row_out_q;
  assign row_idx = rd_ptr_q;
  assign count   = count_q;
  assign state   = state_q;
  assign err     = err_q;

endmodule
`default_nettype wire

// File: tb/tb_weave_draft_loader.sv
`default_nettype none
// ============================================================================
// Module   : tb_weave_draft_loader
// Purpose  : Directed self-checking bench for weave_draft_loader (8x8 build).
// Revision : 1.0 - initial release
// ============================================================================
module tb_weave_draft_loader;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       load_en = 1'b0;
  logic       wr_stb = 1'b0;
  logic [7:0] wr_data = '0;
  logic       wr_par = 1'b0;
  logic       step = 1'b0;
  logic       wr_ack;
  logic [7:0] row_out;
  logic [2:0] row_idx;
  logic [3:0] count;
  logic [1:0] state;
  logic       err;

  int total = 0;
  int bad   = 0;

  weave_draft_loader #(.WIDTH(8), .DEPTH(8), .SYNC_STAGES(2)) dut (
    .clk(clk), .rst(rst), .load_en(load_en), .wr_stb(wr_stb),
    .wr_data(wr_data), .wr_par(wr_par), .step(step), .wr_ack(wr_ack),
    .row_out(row_out), .row_idx(row_idx), .count(count), .state(state),
    .err(err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_ack(input logic v, input string tag);
    int n = 0;
    while (wr_ack !== v && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk(tag, 32'(wr_ack), 32'(v));
  endtask

  task automatic write_byte(input logic [7:0] d, input logic p);
    wr_data = d;
    wr_par  = p;
    @(negedge clk);
    wr_stb = 1'b1;
    wait_ack(1'b1, "ack_rise");
    wr_stb = 1'b0;
    wait_ack(1'b0, "ack_fall");
    @(negedge clk);
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  task automatic pulse_step();
    step = 1'b1;
    @(negedge clk);
    step = 1'b0;
  endtask

  initial begin
    logic [7:0] exp_rows [5];
    logic [2:0] exp_idx  [5];
    exp_rows = '{8'h42, 8'h24, 8'h03, 8'h84, 8'h48};
    exp_idx  = '{3'd1, 3'd2, 3'd0, 3'd1, 3'd2};

    // Reset values observed while rst is still asserted
    idle_cycles(3);
    chk("rst_state", 32'(state), 32'd0);
    chk("rst_ack", 32'(wr_ack), 32'd0);
    chk("rst_row_out", 32'(row_out), 32'd0);
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_row_idx", 32'(row_idx), 32'd0);
    rst = 1'b0;
    idle_cycles(2);

    // Load three rows then play
    load_en = 1'b1;
    idle_cycles(5);
    chk("load_state", 32'(state), 32'd1);
    write_byte(8'h81, 1'b0);
    write_byte(8'h42, 1'b0);
    write_byte(8'h24, 1'b0);
    chk("load_count", 32'(count), 32'd3);
    chk("load_row_out_zero", 32'(row_out), 32'd0);
    load_en = 1'b0;
    idle_cycles(5);
    chk("play_state", 32'(state), 32'd2);
    chk("play_count", 32'(count), 32'd3);
    chk("play_row0", 32'(row_out), 32'h81);
    chk("play_idx0", 32'(row_idx), 32'd0);

    // Steps across a pass wrap: second pass rotated left by one
    for (int i = 0; i < 5; i++) begin
      pulse_step();
      chk($sformatf("step%0d_row", i), 32'(row_out), 32'(exp_rows[i]));
      chk($sformatf("step%0d_idx", i), 32'(row_idx), 32'(exp_idx[i]));
    end

    // Overflow: nine writes into eight entries
    load_en = 1'b1;
    idle_cycles(5);
    chk("reload_state", 32'(state), 32'd1);
    chk("reload_count_clr", 32'(count), 32'd0);
    chk("reload_row_out_zero", 32'(row_out), 32'd0);
    for (int i = 1; i <= 9; i++) write_byte(8'(i), 1'b0);
    chk("ovf_count", 32'(count), 32'd8);
    chk("ovf_err", 32'(err), 32'd1);
    load_en = 1'b0;
    idle_cycles(5);
    chk("ovf_play_state", 32'(state), 32'd2);
    chk("ovf_play_row0", 32'(row_out), 32'h01);
    for (int i = 0; i < 7; i++) pulse_step();
    chk("ovf_last_row", 32'(row_out), 32'h08);
    chk("ovf_last_idx", 32'(row_idx), 32'd7);
    pulse_step();
    chk("ovf_wrap_row", 32'(row_out), 32'h02);
    chk("ovf_wrap_idx", 32'(row_idx), 32'd0);

    // Reset in the middle of a handshake
    load_en = 1'b1;
    idle_cycles(5);
    write_byte(8'h11, 1'b0);
    write_byte(8'h22, 1'b0);
    wr_data = 8'h33;
    @(negedge clk);
    wr_stb = 1'b1;
    wait_ack(1'b1, "mid_ack_rise");
    #2 rst = 1'b1;
    #1;
    chk("mid_rst_ack", 32'(wr_ack), 32'd0);
    chk("mid_rst_count", 32'(count), 32'd0);
    chk("mid_rst_state", 32'(state), 32'd0);
    wr_stb = 1'b0;
    idle_cycles(2);
    rst = 1'b0;
    idle_cycles(5);
    chk("mid_reload_state", 32'(state), 32'd1);
    write_byte(8'h5A, 1'b0);
    load_en = 1'b0;
    idle_cycles(5);
    chk("mid_reload_count", 32'(count), 32'd1);
    chk("mid_reload_play", 32'(state), 32'd2);
    chk("mid_reload_row", 32'(row_out), 32'h5A);

    // Odd-parity write
    load_en = 1'b1;
    idle_cycles(5);
    write_byte(8'h03, 1'b1);
`ifdef WDL_PARITY_EN
    chk("par_count", 32'(count), 32'd0);
    chk("par_err", 32'(err), 32'd1);
`else
    chk("par_count", 32'(count), 32'd1);
    chk("par_err", 32'(err), 32'd0);
`endif
    load_en = 1'b0;
    idle_cycles(5);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
